// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry circular buffer of {pc, inst}
// pairs with valid/ready handshakes on both ends and a single-cycle flush.
module inst_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_inst,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_inst,
    input  logic          out_ready,
    input  logic          flush,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push;
    logic          pop;
    logic [63:0]   head;

    // Handshake flags come only from registered occupancy, never from the other side's inputs.
    assign in_ready  = (cnt_q != CW'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = cnt_q;

    // A bubble must look like a NOP to decode, so the head is zeroed while empty.
    assign head     = out_valid ? mem_q[rp_q] : 64'h0;
    assign out_pc   = head[63:32];
    assign out_inst = head[31:0];

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                wp_d = wp_q + AW'(1);
            end
            if (pop) begin
                rp_d = rp_q + AW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately left unreset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wp_q] <= {in_pc, in_inst};
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: a queue of expected {pc, inst} entries is
// filled as pushes are driven and drained as the DUT presents its head to decode.
module tb_inst_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          clrn;
    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_inst;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_inst;
    logic          out_ready;
    logic          flush;
    logic [CW-1:0] count;

    int checks;
    int errors;
    logic [63:0] sb [$];

    inst_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_in(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                          input logic ordy, input logic fl);
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Advance one clock and update the scoreboard from the bench's own occupancy model.
    task automatic tick();
        bit do_push;
        bit do_pop;
        logic [63:0] entry;
        do_push = in_valid && (sb.size() != DEPTH) && !flush;
        do_pop  = out_ready && (sb.size() != 0) && !flush;
        entry   = {in_pc, in_inst};
        @(posedge clk);
        #1;
        if (flush) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(entry);
        end
    endtask

    task automatic test_reset();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        clrn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clrn = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d expected 0", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_inst got %h expected 0", out_inst); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_pc got %h expected 0", out_pc); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(i * 4), 32'(32'hA0 + i), 1'b0, 1'b0);
            tick();
        end
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count got %0d expected 4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_in_ready got %b expected 0", in_ready); end
        set_in(1'b1, 32'h10, 32'hA4, 1'b0, 1'b0);
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL fill_fifth_refused got %0d expected 4", count); end
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || {out_pc, out_inst} !== sb[0] || out_pc !== 32'(i * 4)) begin
                errors++;
                $display("[TB] FAIL fill_drain_%0d got v=%b pc=%h inst=%h expected pc=%h inst=%h",
                         i, out_valid, out_pc, out_inst, sb[0][63:32], sb[0][31:0]);
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("[TB] FAIL fill_empty got v=%b count=%0d expected v=0 count=0", out_valid, count); end
    endtask

    task automatic test_streaming();
        set_in(1'b1, 32'h0, 32'h500, 1'b1, 1'b0);
        tick();
        for (int i = 1; i < 12; i++) begin
            set_in(1'b1, 32'(i * 4), 32'(32'h500 + i), 1'b1, 1'b0);
            checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL stream_count_%0d got %0d expected 1", i, count); end
            checks++;
            if (out_pc !== 32'((i - 1) * 4) || {out_pc, out_inst} !== sb[0]) begin
                errors++;
                $display("[TB] FAIL stream_head_%0d got pc=%h inst=%h expected pc=%h inst=%h",
                         i, out_pc, out_inst, sb[0][63:32], sb[0][31:0]);
            end
            tick();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++; if (out_pc !== 32'h2C || out_inst !== 32'h50B) begin errors++; $display("[TB] FAIL stream_last got pc=%h inst=%h expected pc=2c inst=50b", out_pc, out_inst); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drained got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'(32'h100 + i * 4), 32'(32'hB0 + i), 1'b0, 1'b0);
            tick();
        end
        checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre_count got %0d expected 3", count); end
        set_in(1'b1, 32'h40, 32'hBAD, 1'b1, 1'b1);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL flush_count got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid got %b expected 0", out_valid); end
        checks++; if (out_inst !== 32'h0) begin errors++; $display("[TB] FAIL flush_out_inst got %h expected 0", out_inst); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready got %b expected 1", in_ready); end
        set_in(1'b1, 32'h80, 32'hC0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h80 || {out_pc, out_inst} !== sb[0]) begin
            errors++;
            $display("[TB] FAIL flush_next_head got v=%b pc=%h inst=%h expected pc=80 inst=c0", out_valid, out_pc, out_inst);
        end
        tick();
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("[TB] FAIL flush_no_wrong_path got v=%b pc=%h expected empty", out_valid, out_pc); end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(32'h200 + i * 4), 32'(32'hD0 + i), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b1, 32'h300, 32'hEE, 1'b1, 1'b0);
        checks++; if (out_pc !== 32'h200) begin errors++; $display("[TB] FAIL full_head got %h expected 200", out_pc); end
        tick();
        checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL full_simul_count got %0d expected 3", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_simul_in_ready got %b expected 1", in_ready); end
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(32'h200 + i * 4) || {out_pc, out_inst} !== sb[0]) begin
                errors++;
                $display("[TB] FAIL full_drain_%0d got v=%b pc=%h inst=%h expected pc=%h", i, out_valid, out_pc, out_inst, sb[0][63:32]);
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_refused_push got v=%b pc=%h expected empty", out_valid, out_pc); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 32'(32'h600 + i * 4), 32'(32'hF0 + i), 1'b0, 1'b0);
            tick();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL async_pre_count got %0d expected 2", count); end
        #2;
        clrn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_out_valid got %b expected 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL async_count got %0d expected 0", count); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL async_out_pc got %h expected 0", out_pc); end
        sb.delete();
        @(posedge clk);
        #1;
        clrn = 1'b1;
        set_in(1'b1, 32'h700, 32'h77, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (count !== 3'd1 || out_pc !== 32'h700 || {out_pc, out_inst} !== sb[0]) begin
            errors++;
            $display("[TB] FAIL async_restart got count=%0d pc=%h expected count=1 pc=700", count, out_pc);
        end
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clrn   = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_fill();
        test_streaming();
        test_flush();
        test_full_simul();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
